// File: rtl/dragonfang_pkg.sv
// -----------------------------------------------------------------------------
// dragonfang_pkg
// Core-wide sizing constants for the Dragonfang RVV core.
//   NUMBER_FUNCTIONAL_UNITS   : number of identical vector ALU lanes
//   NUMBER_PHYSICAL_REGISTERS : physical vector registers (renamed tag space)
//   ELEN                      : element / datapath width in bits
// Derived widths are provided so every consumer sizes tags the same way.
// The execution pipeline depth (issue edge to output) is fixed at 3 cycles by
// the lane structure and is not a tunable constant.
// -----------------------------------------------------------------------------
package dragonfang_pkg;

    localparam int NUMBER_FUNCTIONAL_UNITS   = 2;
    localparam int NUMBER_PHYSICAL_REGISTERS = 32;
    localparam int ELEN                      = 64;

    // A single-lane build still needs a 1-bit lane select port.
    localparam int FU_TAG_W  = (NUMBER_FUNCTIONAL_UNITS > 1) ? $clog2(NUMBER_FUNCTIONAL_UNITS) : 1;
    localparam int VRG_TAG_W = $clog2(NUMBER_PHYSICAL_REGISTERS);
    localparam int SHAMT_W   = $clog2(ELEN);

endpackage

// File: rtl/riscv_v_pkg.sv
// -----------------------------------------------------------------------------
// riscv_v_pkg
// RVV instruction encodings and the packet types exchanged between the issue
// logic, the vector register group (VRG) and the execution stage. Also holds
// the opcode decoder and the element ALU shared by every lane.
//
// Optional feature macro: EXECUTION_SHIFT_OPS_EN
//   defined   -> vsll / vsrl / vsra decode and execute (shift by vs1[5:0])
//   undefined -> those funct6 encodings decode as unsupported (bubble)
// -----------------------------------------------------------------------------
package riscv_v_pkg;

    import dragonfang_pkg::*;

    // funct3 category: vector-vector integer
    localparam logic [2:0] FUNCT3_OPIVV = 3'b000;

    // funct6 encodings
    localparam logic [5:0] F6_VADD  = 6'b000000;
    localparam logic [5:0] F6_VSUB  = 6'b000010;
    localparam logic [5:0] F6_VMINU = 6'b000100;
    localparam logic [5:0] F6_VMAXU = 6'b000110;
    localparam logic [5:0] F6_VAND  = 6'b001001;
    localparam logic [5:0] F6_VOR   = 6'b001010;
    localparam logic [5:0] F6_VXOR  = 6'b001011;
    localparam logic [5:0] F6_VSLL  = 6'b100101;
    localparam logic [5:0] F6_VSRL  = 6'b101000;
    localparam logic [5:0] F6_VSRA  = 6'b101001;

    // Decoded instruction as delivered by issue; all-zero is a bubble.
    typedef struct packed {
        logic       valid;
        logic [5:0] funct6;
        logic [2:0] funct3;
    } execution_vector_t;

    typedef struct packed {
        logic [VRG_TAG_W-1:0] tag;
        logic [ELEN-1:0]      data;
    } operand_packet_t;

    typedef struct packed {
        operand_packet_t vs2;
        operand_packet_t vs1;
    } operand_data_packet_t;

    typedef struct packed {
        logic                 valid;
        logic [VRG_TAG_W-1:0] tag;
        logic [ELEN-1:0]      data;
    } data_packet_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_MINU,
        ALU_MAXU,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA
    } alu_op_e;

    typedef struct packed {
        logic    supported;
        alu_op_e op;
    } decoded_op_t;

    // Map funct6 to an ALU operation; unknown encodings are flagged unsupported.
    function automatic decoded_op_t decode_opivv(input logic [5:0] funct6);
        decoded_op_t d;
        d.supported = 1'b1;
        d.op        = ALU_ADD;
        case (funct6)
            F6_VADD:  d.op = ALU_ADD;
            F6_VSUB:  d.op = ALU_SUB;
            F6_VMINU: d.op = ALU_MINU;
            F6_VMAXU: d.op = ALU_MAXU;
            F6_VAND:  d.op = ALU_AND;
            F6_VOR:   d.op = ALU_OR;
            F6_VXOR:  d.op = ALU_XOR;
`ifdef EXECUTION_SHIFT_OPS_EN
            F6_VSLL:  d.op = ALU_SLL;
            F6_VSRL:  d.op = ALU_SRL;
            F6_VSRA:  d.op = ALU_SRA;
`endif
            default:  d.supported = 1'b0;
        endcase
        return d;
    endfunction

    // vd = a OP b with a = vs2, b = vs1. Arithmetic wraps modulo 2^ELEN.
    function automatic logic [ELEN-1:0] alu_compute(input alu_op_e         op,
                                                    input logic [ELEN-1:0] a,
                                                    input logic [ELEN-1:0] b);
        logic [ELEN-1:0] r;
        r = '0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_MINU: r = (a < b) ? a : b;
            ALU_MAXU: r = (a > b) ? a : b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
`ifdef EXECUTION_SHIFT_OPS_EN
            ALU_SLL:  r = a << b[SHAMT_W-1:0];
            ALU_SRL:  r = a >> b[SHAMT_W-1:0];
            ALU_SRA:  r = $unsigned($signed(a) >>> b[SHAMT_W-1:0]);
`endif
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/execution_lane.sv
// -----------------------------------------------------------------------------
// execution_lane
// One vector ALU lane: S0 issue register -> S1 operand register -> ALU ->
// S2 result register -> S3 output register. Operand bypass is resolved by the
// parent; this lane exposes its S0 operands and receives the resolved values
// that S1 captures.
//
// Ports
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   issue_valid_i       : capture an instruction into S0 this edge
//   issue_op_i          : decoded ALU operation
//   issue_vd_tag_i      : destination physical tag
//   issue_operands_i    : vs2/vs1 tags and VRG-supplied data
//   s0_operands_o       : S0 operand tags/data for the bypass network
//   s1_vs2_data_i       : bypass-resolved vs2 for S1 capture
//   s1_vs1_data_i       : bypass-resolved vs1 for S1 capture
//   s1_fwd_o            : S1 valid/tag with the combinational ALU result
//   s2_fwd_o, s3_fwd_o  : S2 / S3 registered valid/tag/data
//
// Invalid stages hold all-zero tag/data so S3 can feed the output mux directly.
// -----------------------------------------------------------------------------
module execution_lane
    import dragonfang_pkg::*;
    import riscv_v_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 issue_valid_i,
    input  alu_op_e              issue_op_i,
    input  logic [VRG_TAG_W-1:0] issue_vd_tag_i,
    input  operand_data_packet_t issue_operands_i,
    output operand_data_packet_t s0_operands_o,
    input  logic [ELEN-1:0]      s1_vs2_data_i,
    input  logic [ELEN-1:0]      s1_vs1_data_i,
    output data_packet_t         s1_fwd_o,
    output data_packet_t         s2_fwd_o,
    output data_packet_t         s3_fwd_o
);

    // S0: issue register
    logic                 s0_valid_q, s0_valid_d;
    alu_op_e              s0_op_q, s0_op_d;
    logic [VRG_TAG_W-1:0] s0_vd_q, s0_vd_d;
    operand_data_packet_t s0_opnd_q, s0_opnd_d;

    // S1: operand register (post-bypass)
    logic                 s1_valid_q, s1_valid_d;
    alu_op_e              s1_op_q, s1_op_d;
    logic [VRG_TAG_W-1:0] s1_vd_q, s1_vd_d;
    logic [ELEN-1:0]      s1_vs2_q, s1_vs2_d;
    logic [ELEN-1:0]      s1_vs1_q, s1_vs1_d;

    // S2: result register, S3: output register
    data_packet_t         s2_q, s2_d;
    data_packet_t         s3_q, s3_d;

    logic [ELEN-1:0]      alu_result;

    always_comb begin
        s0_valid_d = issue_valid_i;
        s0_op_d    = issue_valid_i ? issue_op_i       : ALU_ADD;
        s0_vd_d    = issue_valid_i ? issue_vd_tag_i   : '0;
        s0_opnd_d  = issue_valid_i ? issue_operands_i : '0;

        s1_valid_d = s0_valid_q;
        s1_op_d    = s0_op_q;
        s1_vd_d    = s0_vd_q;
        // The bypass inputs are meaningless for an empty S0; keep S1 clean.
        s1_vs2_d   = s0_valid_q ? s1_vs2_data_i : '0;
        s1_vs1_d   = s0_valid_q ? s1_vs1_data_i : '0;

        alu_result = alu_compute(s1_op_q, s1_vs2_q, s1_vs1_q);

        s2_d = '0;
        if (s1_valid_q) begin
            s2_d.valid = 1'b1;
            s2_d.tag   = s1_vd_q;
            s2_d.data  = alu_result;
        end

        s3_d = s2_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
            s0_op_q    <= ALU_ADD;
            s0_vd_q    <= '0;
            s0_opnd_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_op_q    <= ALU_ADD;
            s1_vd_q    <= '0;
            s1_vs2_q   <= '0;
            s1_vs1_q   <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_op_q    <= s0_op_d;
            s0_vd_q    <= s0_vd_d;
            s0_opnd_q  <= s0_opnd_d;
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_vd_q    <= s1_vd_d;
            s1_vs2_q   <= s1_vs2_d;
            s1_vs1_q   <= s1_vs1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
        end
    end

    assign s0_operands_o = s0_opnd_q;
    // S1's forwarding source is the value S2 is about to capture.
    assign s1_fwd_o      = s2_d;
    assign s2_fwd_o      = s2_q;
    assign s3_fwd_o      = s3_q;

endmodule

// File: rtl/execution.sv
// -----------------------------------------------------------------------------
// execution
// Vector execution stage (SEW = 64) for the Dragonfang RVV core. One renamed
// vector-vector integer instruction may issue per cycle to one of
// NUMBER_FUNCTIONAL_UNITS lanes; the tagged result appears on vrg_output_data
// three cycles after the issue edge, for exactly one cycle.
//
// Interface protocol: valid-only, no backpressure. An instruction is accepted
// in any cycle where execution_vector.valid=1, funct3=OPIVV and funct6 is a
// supported operation; everything else is a bubble. vrg_output_data.valid
// marks a single-cycle writeback the VRG must absorb.
//
// Ports
//   clock               : rising-edge clock
//   reset               : synchronous active-high reset
//   execution_vector    : {valid, funct6, funct3}
//   functional_unit_tag : target lane (out-of-range values issue nowhere)
//   destination_vrg_tag : physical tag of vd
//   vrg_input_data      : {vs2.tag, vs2.data, vs1.tag, vs1.data}
//   vrg_output_data     : {valid, tag, data} writeback
//
// Optional feature macro: EXECUTION_SHIFT_OPS_EN (adds vsll/vsrl/vsra).
// -----------------------------------------------------------------------------
module execution
    import dragonfang_pkg::*;
    import riscv_v_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  execution_vector_t    execution_vector,
    input  logic [FU_TAG_W-1:0]  functional_unit_tag,
    input  logic [VRG_TAG_W-1:0] destination_vrg_tag,
    input  operand_data_packet_t vrg_input_data,
    output data_packet_t         vrg_output_data
);

    localparam int NFU     = NUMBER_FUNCTIONAL_UNITS;
    // Forwarding sources flattened in priority order:
    // [0 .. NFU-1] = S1 of each lane, then S2, then S3; lower index wins.
    localparam int NUM_SRC = 3 * NFU;

    decoded_op_t          decoded;
    logic                 issue_ok;

    data_packet_t         fwd_src [NUM_SRC];
    operand_data_packet_t s0_opnd [NFU];
    logic [ELEN-1:0]      byp_vs2 [NFU];
    logic [ELEN-1:0]      byp_vs1 [NFU];
    data_packet_t         out_sel;

    assign decoded  = decode_opivv(execution_vector.funct6);
    assign issue_ok = execution_vector.valid
                   && (execution_vector.funct3 == FUNCT3_OPIVV)
                   && decoded.supported;

    for (genvar l = 0; l < NFU; l++) begin : g_lane
        logic lane_issue;

        // A tag that names no existing lane matches none of these compares.
        assign lane_issue = issue_ok && (functional_unit_tag == FU_TAG_W'(l));

        execution_lane u_lane (
            .clock            (clock),
            .reset            (reset),
            .issue_valid_i    (lane_issue),
            .issue_op_i       (decoded.op),
            .issue_vd_tag_i   (destination_vrg_tag),
            .issue_operands_i (vrg_input_data),
            .s0_operands_o    (s0_opnd[l]),
            .s1_vs2_data_i    (byp_vs2[l]),
            .s1_vs1_data_i    (byp_vs1[l]),
            .s1_fwd_o         (fwd_src[l]),
            .s2_fwd_o         (fwd_src[NFU + l]),
            .s3_fwd_o         (fwd_src[2*NFU + l])
        );
    end

    // Operand bypass: scan from lowest to highest priority so the youngest
    // (and, within a stage, lowest-lane) valid match is the one that sticks.
    always_comb begin
        for (int l = 0; l < NFU; l++) begin
            byp_vs2[l] = s0_opnd[l].vs2.data;
            byp_vs1[l] = s0_opnd[l].vs1.data;
            for (int s = NUM_SRC - 1; s >= 0; s--) begin
                if (fwd_src[s].valid && (fwd_src[s].tag == s0_opnd[l].vs2.tag)) begin
                    byp_vs2[l] = fwd_src[s].data;
                end
                if (fwd_src[s].valid && (fwd_src[s].tag == s0_opnd[l].vs1.tag)) begin
                    byp_vs1[l] = fwd_src[s].data;
                end
            end
        end
    end

    // Output mux: single issue guarantees at most one valid S3 entry; lower
    // lane still wins to keep the selection deterministic.
    always_comb begin
        out_sel = '0;
        for (int l = NFU - 1; l >= 0; l--) begin
            if (fwd_src[2*NFU + l].valid) begin
                out_sel = fwd_src[2*NFU + l];
            end
        end
    end

    assign vrg_output_data = out_sel;

endmodule

// File: tb/tb_execution.sv
module tb_execution;
  import dragonfang_pkg::*;
  import riscv_v_pkg::*;

  localparam int PW = 1 + VRG_TAG_W + ELEN;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  execution_vector_t    execution_vector;
  logic [FU_TAG_W-1:0]  functional_unit_tag;
  logic [VRG_TAG_W-1:0] destination_vrg_tag;
  operand_data_packet_t vrg_input_data;
  data_packet_t         vrg_output_data;

  execution dut (
    .clock               (clock),
    .reset               (reset),
    .execution_vector    (execution_vector),
    .functional_unit_tag (functional_unit_tag),
    .destination_vrg_tag (destination_vrg_tag),
    .vrg_input_data      (vrg_input_data),
    .vrg_output_data     (vrg_output_data)
  );

  // scoreboard
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic mon_en = 1'b0;
  logic [PW-1:0] exp_q[$];
  int            due_q[$];
  string         name_q[$];

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every cycle the output must equal the scheduled entry, or all-zero.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      #2;
      if (mon_en) begin
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          check(name_q.pop_front(), vrg_output_data, exp_q.pop_front());
          void'(due_q.pop_front());
        end else begin
          check("idle", vrg_output_data, '0);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] f6, input logic [2:0] f3,
                       input logic [FU_TAG_W-1:0] fu, input logic [VRG_TAG_W-1:0] vd,
                       input logic [VRG_TAG_W-1:0] t2, input logic [ELEN-1:0] d2,
                       input logic [VRG_TAG_W-1:0] t1, input logic [ELEN-1:0] d1,
                       input logic expect_out, input logic [ELEN-1:0] exp_data,
                       input string name);
    execution_vector.valid  = v;
    execution_vector.funct6 = f6;
    execution_vector.funct3 = f3;
    functional_unit_tag     = fu;
    destination_vrg_tag     = vd;
    vrg_input_data.vs2.tag  = t2;
    vrg_input_data.vs2.data = d2;
    vrg_input_data.vs1.tag  = t1;
    vrg_input_data.vs1.data = d1;
    if (expect_out) begin
      exp_q.push_back({1'b1, vd, exp_data});
      due_q.push_back(cyc + 4);
      name_q.push_back(name);
    end
    tick();
  endtask

  task automatic bubble(input int n);
    execution_vector    = '0;
    functional_unit_tag = '0;
    destination_vrg_tag = '0;
    vrg_input_data      = '0;
    repeat (n) tick();
  endtask

  initial begin
    execution_vector    = '0;
    functional_unit_tag = '0;
    destination_vrg_tag = '0;
    vrg_input_data      = '0;

    // reset for one cycle, then bubbles
    reset = 1'b1;
    tick();
    mon_en = 1'b1;
    reset  = 1'b0;
    bubble(3);

    // independent vor, then dependent vor forwarded from S1 of the other lane
    drive(1, F6_VOR, FUNCT3_OPIVV, 0, 23, 1, 64'hbd9f4ca5088221d2, 2, 64'h763be6b053143df7,
          1, 64'hffbfeeb55b963df7, "vor_indep");
    drive(1, F6_VOR, FUNCT3_OPIVV, 1, 17, 23, 64'h6c1c9455f3821c99, 3, 64'h950e3d919f9c49ab,
          1, 64'hffbfffb5df9e7dff, "vor_fwd_s1");
    // wrap and unsigned compare
    drive(1, F6_VADD, FUNCT3_OPIVV, 0, 6, 4, 64'hffffffffffffffff, 5, 64'h1,
          1, 64'h0, "vadd_wrap");
    drive(1, F6_VSUB, FUNCT3_OPIVV, 1, 9, 7, 64'h0, 8, 64'h1,
          1, 64'hffffffffffffffff, "vsub_wrap");
    drive(1, F6_VMAXU, FUNCT3_OPIVV, 0, 12, 10, 64'h8000000000000000, 11, 64'h7fffffffffffffff,
          1, 64'h8000000000000000, "vmaxu");
    drive(1, F6_VMINU, FUNCT3_OPIVV, 1, 15, 13, 64'h8000000000000000, 14, 64'h7fffffffffffffff,
          1, 64'h7fffffffffffffff, "vminu");
    // vs2 from S2 (tag 12), vs1 from S3 (tag 9), supplied data stale
    drive(1, F6_VXOR, FUNCT3_OPIVV, 0, 18, 12, 64'h0, 9, 64'h0,
          1, 64'h7fffffffffffffff, "vxor_fwd_s2_s3");
    // vs2 from S1 (tag 18), vs1 unmatched
    drive(1, F6_VAND, FUNCT3_OPIVV, 1, 19, 18, 64'h0, 20, 64'h00ff00ff00ff00ff,
          1, 64'h00ff00ff00ff00ff, "vand_fwd_s1");
    // two producers of tag 25 in flight: the younger one must win
    drive(1, F6_VADD, FUNCT3_OPIVV, 0, 25, 26, 64'h10, 27, 64'h20, 1, 64'h30, "vadd_old25");
    drive(1, F6_VADD, FUNCT3_OPIVV, 1, 25, 26, 64'h100, 27, 64'h200, 1, 64'h300, "vadd_new25");
    drive(1, F6_VOR, FUNCT3_OPIVV, 0, 28, 25, 64'h0, 29, 64'h1, 1, 64'h301, "vor_youngest");
    // bubbles: valid=0, unsupported funct6, wrong funct3
    drive(0, F6_VADD, FUNCT3_OPIVV, 0, 30, 1, 64'h5, 2, 64'h6, 0, 64'h0, "bub_valid");
    drive(1, 6'b111111, FUNCT3_OPIVV, 1, 31, 1, 64'h5, 2, 64'h6, 0, 64'h0, "bub_f6");
    drive(1, F6_VADD, 3'b001, 0, 0, 1, 64'h5, 2, 64'h6, 0, 64'h0, "bub_f3");
    // tag 0 matches only invalid stages: supplied data must be used
    drive(1, F6_VADD, FUNCT3_OPIVV, 0, 1, 30, 64'h5, 0, 64'h7, 1, 64'hc, "vadd_stale");
    bubble(5);

    // simultaneous reset and issue: dropped
    reset = 1'b1;
    drive(1, F6_VADD, FUNCT3_OPIVV, 1, 2, 3, 64'h1, 4, 64'h1, 0, 64'h0, "rst_issue");
    reset = 1'b0;
    bubble(3);

    // reset the cycle after issue: never appears
    drive(1, F6_VAND, FUNCT3_OPIVV, 0, 3, 5, 64'hffffffffffffffff, 6, 64'h1234, 0, 64'h0, "rst_flight");
    reset = 1'b1;
    bubble(1);
    reset = 1'b0;
    bubble(5);

    // recovery after reset
    drive(1, F6_VADD, FUNCT3_OPIVV, 1, 4, 7, 64'h1, 8, 64'h2, 1, 64'h3, "vadd_after_rst");

`ifdef EXECUTION_SHIFT_OPS_EN
    drive(1, F6_VSRA, FUNCT3_OPIVV, 0, 10, 11, 64'h8000000000000000, 12, 64'h4,
          1, 64'hf800000000000000, "vsra");
    drive(1, F6_VSLL, FUNCT3_OPIVV, 1, 13, 14, 64'h1, 15, 64'h3f,
          1, 64'h8000000000000000, "vsll");
    drive(1, F6_VSRL, FUNCT3_OPIVV, 0, 16, 17, 64'hf0, 18, 64'h43,
          1, 64'h1e, "vsrl_mask");
`else
    drive(1, F6_VSRA, FUNCT3_OPIVV, 0, 10, 11, 64'h8000000000000000, 12, 64'h4,
          0, 64'h0, "vsra_off");
    drive(1, F6_VSLL, FUNCT3_OPIVV, 1, 13, 14, 64'h1, 15, 64'h3f,
          0, 64'h0, "vsll_off");
`endif
    bubble(6);

    check("drain", PW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
